// File: rtl/rl_track_environment_if.sv
// rl_track_environment_if: action handshake between the SNN network and the track environment
//   act_vec   : 00 hold, 01 left, 10 right, 11 hold
//   act_valid : network presents an action
//   act_ready : environment accepts an action this cycle
interface rl_track_environment_if;
  logic [1:0] act_vec;
  logic       act_valid;
  logic       act_ready;
  modport master (output act_vec, act_valid, input act_ready);
  modport slave  (input act_vec, act_valid, output act_ready);
endinterface

// File: rtl/rl_track_environment.sv
// rl_track_environment: 1-D track environment closing the loop around the hippocampal SNN
//   clk, reset_n (sync, active-low), run (0 parks in IDLE)
//   act          : action handshake (rl_track_environment_if.slave)
//   place_spike  : one-hot place-cell spike for the current cell, every SPIKE_PERIOD cycles
//   pos          : current cell
//   reward       : goal pulse; punish : wall-bump or timeout pulse
//   episode_done : episode end pulse; episode_cnt : completed episodes (wraps)
//   Define STEP_LIMIT_EN to end episodes as a timeout after MAX_STEPS steps.
module rl_track_environment #(
  parameter int TRACK_LEN    = 8,
  parameter int POS_W        = 3,
  parameter int START_POS    = 0,
  parameter int GOAL_POS     = 7,
  parameter int SPIKE_PERIOD = 4,
  parameter int MAX_STEPS    = 32,
  parameter int EP_W         = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 run,
  rl_track_environment_if.slave act,
  output logic [TRACK_LEN-1:0] place_spike,
  output logic [POS_W-1:0]     pos,
  output logic                 reward,
  output logic                 punish,
  output logic                 episode_done,
  output logic [EP_W-1:0]      episode_cnt
);
  localparam int SW = $clog2(SPIKE_PERIOD);
  localparam logic [SW-1:0]    SPK_LAST = SW'(SPIKE_PERIOD - 1);
  localparam logic [POS_W-1:0] START = POS_W'(START_POS);
  localparam logic [POS_W-1:0] GOAL  = POS_W'(GOAL_POS);
  localparam logic [POS_W-1:0] LAST  = POS_W'(TRACK_LEN - 1);
  typedef enum logic [1:0] {IDLE, PRESENT, UPDATE, REWARD} state_t;
  state_t state, state_nxt;
  logic [SW-1:0]    spk_cnt;
  logic [1:0]       act_r;
  logic [POS_W-1:0] pos_mv;
  logic             bump, goal, tout, punish_r, tout_r;
`ifdef STEP_LIMIT_EN
  localparam int STW = $clog2(MAX_STEPS + 1);
  localparam logic [STW-1:0] STEP_MAX = STW'(MAX_STEPS);
  logic [STW-1:0] step_cnt;
`endif
  assign act.act_ready = (state == PRESENT) && run;
  assign place_spike   = (state == PRESENT && spk_cnt == '0) ? {{(TRACK_LEN-1){1'b0}}, 1'b1} << pos : '0;
  assign reward        = state == REWARD;
  assign punish        = punish_r;
  assign episode_done  = (state == REWARD) || tout_r;
  always_comb begin
    bump   = (act_r == 2'b01 && pos == '0) || (act_r == 2'b10 && pos == LAST);
    pos_mv = bump ? pos : act_r == 2'b01 ? pos - 1'b1 : act_r == 2'b10 ? pos + 1'b1 : pos;
    goal   = pos_mv == GOAL;
`ifdef STEP_LIMIT_EN
    tout   = !goal && (step_cnt + 1'b1 == STEP_MAX);
`else
    tout   = 1'b0;
`endif
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = run ? PRESENT : IDLE;
      PRESENT: state_nxt = !run ? IDLE : act.act_valid ? UPDATE : PRESENT;
      UPDATE:  state_nxt = goal ? REWARD : (tout && !run) ? IDLE : PRESENT;
      REWARD:  state_nxt = run ? PRESENT : IDLE;
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= IDLE;
      pos         <= START;
      spk_cnt     <= '0;
      act_r       <= 2'b00;
      punish_r    <= 1'b0;
      tout_r      <= 1'b0;
      episode_cnt <= '0;
`ifdef STEP_LIMIT_EN
      step_cnt    <= '0;
`endif
    end else begin
      state    <= state_nxt;
      spk_cnt  <= (state == PRESENT && state_nxt == PRESENT) ? (spk_cnt == SPK_LAST ? '0 : spk_cnt + 1'b1) : '0;
      punish_r <= (state == UPDATE) && (bump || tout);
      tout_r   <= (state == UPDATE) && tout;
      if (act.act_valid && act.act_ready) act_r <= act.act_vec;
      if (state == UPDATE) pos <= tout ? START : pos_mv;
      if (state == REWARD) pos <= START;
      if (state == REWARD || (state == UPDATE && tout)) episode_cnt <= episode_cnt + 1'b1;
`ifdef STEP_LIMIT_EN
      if (state == UPDATE) step_cnt <= tout ? '0 : step_cnt + 1'b1;
      if (state == REWARD) step_cnt <= '0;
`endif
    end
  end
endmodule

// File: tb/tb_rl_track_environment.sv
// tb_rl_track_environment: directed self-checking bench for rl_track_environment
module tb_rl_track_environment;
  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       run = 1'b0;
  logic [7:0] place_spike;
  logic [2:0] pos;
  logic       reward, punish, episode_done;
  logic [7:0] episode_cnt;
  int checks = 0;
  int errors = 0;
  rl_track_environment_if ai();
  rl_track_environment dut (
    .clk(clk), .reset_n(reset_n), .run(run), .act(ai),
    .place_spike(place_spike), .pos(pos), .reward(reward), .punish(punish),
    .episode_done(episode_done), .episode_cnt(episode_cnt)
  );
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask
  task automatic do_act(input logic [1:0] v);
    ai.act_vec   = v;
    ai.act_valid = 1'b1;
    tick;
    ai.act_valid = 1'b0;
    chk("upd_ready", ai.act_ready, 0);
    chk("upd_spike", place_spike, 0);
    tick;
  endtask
  initial begin
    ai.act_vec   = 2'b00;
    ai.act_valid = 1'b0;
    tick;
    tick;
    chk("rst_pos", pos, 0);
    chk("rst_reward", reward, 0);
    chk("rst_punish", punish, 0);
    chk("rst_done", episode_done, 0);
    chk("rst_ready", ai.act_ready, 0);
    chk("rst_spike", place_spike, 0);
    chk("rst_epcnt", episode_cnt, 0);
    reset_n = 1'b1;
    run = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick;
      chk("spike_train", place_spike, (i % 4 == 0) ? 32'h01 : 32'h00);
      chk("present_ready", ai.act_ready, 1);
    end
    for (int k = 1; k <= 6; k++) begin
      do_act(2'b10);
      chk("right_pos", pos, k);
      chk("right_spike", place_spike, 32'd1 << k);
      chk("right_reward", reward, 0);
      chk("right_punish", punish, 0);
    end
    do_act(2'b10);
    chk("goal_pos", pos, 7);
    chk("goal_reward", reward, 1);
    chk("goal_done", episode_done, 1);
    chk("goal_punish", punish, 0);
    tick;
    chk("post_reward", reward, 0);
    chk("post_done", episode_done, 0);
    chk("post_pos", pos, 0);
    chk("post_epcnt", episode_cnt, 1);
    chk("post_spike", place_spike, 32'h01);
    do_act(2'b01);
    chk("wall_pos", pos, 0);
    chk("wall_punish", punish, 1);
    chk("wall_reward", reward, 0);
    tick;
    chk("wall_punish_len", punish, 0);
    do_act(2'b11);
    chk("hold11_pos", pos, 0);
    chk("hold11_punish", punish, 0);
    do_act(2'b00);
    chk("hold00_pos", pos, 0);
    chk("hold00_punish", punish, 0);
    do_act(2'b10);
    do_act(2'b10);
    chk("two_right_pos", pos, 2);
    ai.act_vec   = 2'b10;
    ai.act_valid = 1'b1;
    run = 1'b0;
    #1;
    chk("rundrop_ready", ai.act_ready, 0);
    tick;
    tick;
    tick;
    chk("idle_pos", pos, 2);
    chk("idle_spike", place_spike, 0);
    chk("idle_ready", ai.act_ready, 0);
    ai.act_valid = 1'b0;
    run = 1'b1;
    tick;
    chk("resume_spike", place_spike, 32'h04);
    chk("resume_ready", ai.act_ready, 1);
    ai.act_valid = 1'b1;
    tick;
    ai.act_valid = 1'b0;
    reset_n = 1'b0;
    tick;
    chk("updrst_pos", pos, 0);
    chk("updrst_epcnt", episode_cnt, 0);
    chk("updrst_punish", punish, 0);
    chk("updrst_ready", ai.act_ready, 0);
    chk("updrst_spike", place_spike, 0);
    reset_n = 1'b1;
`ifdef STEP_LIMIT_EN
    tick;
    for (int s = 1; s <= 32; s++) begin
      do_act(2'b00);
      chk("tout_punish", punish, s == 32);
      chk("tout_done", episode_done, s == 32);
      chk("tout_reward", reward, 0);
    end
    chk("tout_pos", pos, 0);
    chk("tout_epcnt", episode_cnt, 1);
    for (int s = 1; s <= 32; s++) begin
      do_act(s > 25 ? 2'b10 : 2'b00);
      chk("lastgoal_punish", punish, 0);
      chk("lastgoal_reward", reward, s == 32);
    end
    tick;
    chk("lastgoal_epcnt", episode_cnt, 2);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
